gelato_decode_pipe: RTL and testbench

GELATO_DECODE_PIPE -- requirements
Module: gelato_decode_pipe

---
 rtl/gelato_decode_pipe.sv | 244 ++++++++++++++++++++++++
 tb/tb_gelato_decode_pipe.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gelato_decode_pipe.sv
// gelato_decode_pipe
// Decodes one raw instruction at a time, issues a split-table update
// (next PC, stall, activate) for the owning warp, and queues the decoded
// context, together with the thread mask returned by the split table,
// into a small FIFO that feeds the I-buffer.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   rdy                 global enable; low freezes every register
//   in_*                fetch side: valid/ready, inst, pc, warp, split
//   sp_*                split-table update: valid/ready, warp, split,
//                       activate, stall, next pc; sp_mask comes back in
//   out_*               I-buffer side: valid/ready plus decoded fields
//   out_count           FIFO occupancy
//
// Handshake rule (all three interfaces): a transfer happens on a rising
// clk edge where valid, ready and rdy are all high. valid never depends
// on the consumer's ready of the same interface.
module gelato_decode_pipe #(
  parameter int PC_W    = 32,
  parameter int WARP_W  = 5,
  parameter int SPLIT_W = 4,
  parameter int THREADS = 32,
  parameter int DEPTH   = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     rdy,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_inst,
  input  logic [PC_W-1:0]          in_pc,
  input  logic [WARP_W-1:0]        in_warp,
  input  logic [SPLIT_W-1:0]       in_split,
  output logic                     sp_valid,
  input  logic                     sp_ready,
  output logic [WARP_W-1:0]        sp_warp,
  output logic [SPLIT_W-1:0]       sp_split,
  output logic                     sp_activate,
  output logic                     sp_stall,
  output logic [PC_W-1:0]          sp_pc,
  input  logic [THREADS-1:0]       sp_mask,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [PC_W-1:0]          out_pc,
  output logic [WARP_W-1:0]        out_warp,
  output logic [THREADS-1:0]       out_mask,
  output logic [6:0]               out_opcode,
  output logic [2:0]               out_funct3,
  output logic [6:0]               out_funct7,
  output logic [4:0]               out_rd,
  output logic [4:0]               out_rs1,
  output logic [4:0]               out_rs2,
  output logic [31:0]              out_imm,
  output logic                     out_illegal,
  output logic [$clog2(DEPTH):0]   out_count
);

  localparam int AW = $clog2(DEPTH);

  // Opcode values shared with gelato_macros.svh (RV32 base encodings;
  // NOOP uses the MISC-MEM slot).
  localparam logic [6:0] OP_LUI    = 7'h37;
  localparam logic [6:0] OP_AUIPC  = 7'h17;
  localparam logic [6:0] OP_JAL    = 7'h6F;
  localparam logic [6:0] OP_JALR   = 7'h67;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_LOAD   = 7'h03;
  localparam logic [6:0] OP_STORE  = 7'h23;
  localparam logic [6:0] OP_ARITHI = 7'h13;
  localparam logic [6:0] OP_ARITH  = 7'h33;
  localparam logic [6:0] OP_NOOP   = 7'h0F;

  typedef enum logic {IDLE, SPLIT} state_t;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [WARP_W-1:0]  warp;
    logic [THREADS-1:0] mask;
    logic [6:0]         opcode;
    logic [2:0]         funct3;
    logic [6:0]         funct7;
    logic [4:0]         rd;
    logic [4:0]         rs1;
    logic [4:0]         rs2;
    logic [31:0]        imm;
    logic               illegal;
  } entry_t;

  state_t               state_q, state_d;
  logic [31:0]          inst_q;
  logic [PC_W-1:0]      pc_q;
  logic [WARP_W-1:0]    warp_q;
  logic [SPLIT_W-1:0]   split_q;

  entry_t               mem [DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count_q;

  entry_t               dec;
  entry_t               head;
  logic [6:0]           op;
  logic                 full, has_data;
  logic                 in_fire, sp_fire, out_fire;
  logic                 dec_activate, dec_stall;
  logic [PC_W-1:0]      dec_next_pc;

  // ---------------- decode of the held instruction ----------------
  assign op = inst_q[6:0];

  always_comb begin
    dec        = '0;
    dec.pc     = pc_q;
    dec.warp   = warp_q;
    dec.mask   = sp_mask;
    dec.opcode = op;
    case (op)
      OP_LUI, OP_AUIPC: begin
        dec.rd  = inst_q[11:7];
        dec.imm = {inst_q[31:12], 12'h000};
      end
      OP_JAL: begin
        dec.rd  = inst_q[11:7];
        dec.imm = {{12{inst_q[31]}}, inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};
      end
      OP_JALR, OP_LOAD, OP_ARITHI: begin
        dec.rd     = inst_q[11:7];
        dec.rs1    = inst_q[19:15];
        dec.funct3 = inst_q[14:12];
        dec.imm    = {{20{inst_q[31]}}, inst_q[31:20]};
      end
      OP_BRANCH: begin
        dec.rs1    = inst_q[19:15];
        dec.rs2    = inst_q[24:20];
        dec.funct3 = inst_q[14:12];
        dec.imm    = {{20{inst_q[31]}}, inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
      end
      OP_STORE: begin
        dec.rs1    = inst_q[19:15];
        dec.rs2    = inst_q[24:20];
        dec.funct3 = inst_q[14:12];
        dec.imm    = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
      end
      OP_ARITH: begin
        dec.rd     = inst_q[11:7];
        dec.rs1    = inst_q[19:15];
        dec.rs2    = inst_q[24:20];
        dec.funct3 = inst_q[14:12];
        dec.funct7 = inst_q[31:25];
      end
      OP_NOOP: ;
      default: dec.illegal = 1'b1;
    endcase
  end

  // BEQ/BNE keep the split active path off; every other instruction
  // activates. Control-flow that cannot be resolved here stalls the warp.
  assign dec_activate = !((op == OP_BRANCH) && (inst_q[14:13] == 2'b00));
  assign dec_stall    = (op == OP_AUIPC) || (op == OP_BRANCH) ||
                        (op == OP_JALR) || dec.illegal;
  assign dec_next_pc  = (op == OP_JAL) ? pc_q + PC_W'($signed(dec.imm))
                                       : pc_q + PC_W'(4);

  // ---------------- handshakes ----------------
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign has_data = (count_q != '0);
  assign out_valid = rdy && has_data;
  assign out_fire  = out_valid && out_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign sp_valid  = rdy && (state_q == SPLIT) && (!full || out_fire);
  assign sp_fire   = sp_valid && sp_ready;
  // rst_n gate keeps in_ready low while reset is asserted.
  assign in_ready  = rdy && rst_n && ((state_q == IDLE) || sp_fire);
  assign in_fire   = in_valid && in_ready;

  // ---------------- FSM ----------------
  always_comb begin
    state_d = state_q;
    if (in_fire)      state_d = SPLIT;
    else if (sp_fire) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      inst_q  <= '0;
      pc_q    <= '0;
      warp_q  <= '0;
      split_q <= '0;
    end else begin
      state_q <= state_d;
      if (in_fire) begin
        inst_q  <= in_inst;
        pc_q    <= in_pc;
        warp_q  <= in_warp;
        split_q <= in_split;
      end
    end
  end

  // Split-table outputs are driven only while an instruction is held.
  assign sp_warp     = (state_q == SPLIT) ? warp_q       : '0;
  assign sp_split    = (state_q == SPLIT) ? split_q      : '0;
  assign sp_activate = (state_q == SPLIT) && dec_activate;
  assign sp_stall    = (state_q == SPLIT) && dec_stall;
  assign sp_pc       = (state_q == SPLIT) ? dec_next_pc  : '0;

  // ---------------- output FIFO ----------------
  always_ff @(posedge clk) begin
    if (sp_fire) mem[wr_ptr] <= dec;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (sp_fire)  wr_ptr <= wr_ptr + AW'(1);
      if (out_fire) rd_ptr <= rd_ptr + AW'(1);
      case ({sp_fire, out_fire})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Empty FIFO shows all-zero data so stale entries never leak out.
  assign head        = has_data ? mem[rd_ptr] : '0;
  assign out_pc      = head.pc;
  assign out_warp    = head.warp;
  assign out_mask    = head.mask;
  assign out_opcode  = head.opcode;
  assign out_funct3  = head.funct3;
  assign out_funct7  = head.funct7;
  assign out_rd      = head.rd;
  assign out_rs1     = head.rs1;
  assign out_rs2     = head.rs2;
  assign out_imm     = head.imm;
  assign out_illegal = head.illegal;
  assign out_count   = count_q;

endmodule

// File: tb/tb_gelato_decode_pipe.sv
// Testbench for gelato_decode_pipe: directed and randomized instruction
// streams. Instructions are built by encoding chosen fields, so the
// expected decode is the set of fields that was picked.
module tb_gelato_decode_pipe;

  localparam int DEPTH = 4;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic [4:0]  warp;
    logic [3:0]  split;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        illegal;
    logic        activate;
    logic        stall;
    logic [31:0] sp_pc;
    logic [31:0] mask;
  } ent_t;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        rdy;
  logic        in_valid, in_ready;
  logic [31:0] in_inst, in_pc;
  logic [4:0]  in_warp;
  logic [3:0]  in_split;
  logic        sp_valid, sp_ready;
  logic [4:0]  sp_warp;
  logic [3:0]  sp_split;
  logic        sp_activate, sp_stall;
  logic [31:0] sp_pc;
  logic [31:0] sp_mask;
  logic        out_valid, out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_warp;
  logic [31:0] out_mask;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [4:0]  out_rd, out_rs1, out_rs2;
  logic [31:0] out_imm;
  logic        out_illegal;
  logic [2:0]  out_count;

  always #5 clk = ~clk;

  gelato_decode_pipe #(.PC_W(32), .WARP_W(5), .SPLIT_W(4), .THREADS(32), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .in_warp(in_warp), .in_split(in_split),
    .sp_valid(sp_valid), .sp_ready(sp_ready), .sp_warp(sp_warp), .sp_split(sp_split),
    .sp_activate(sp_activate), .sp_stall(sp_stall), .sp_pc(sp_pc), .sp_mask(sp_mask),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_warp(out_warp),
    .out_mask(out_mask), .out_opcode(out_opcode), .out_funct3(out_funct3),
    .out_funct7(out_funct7), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_illegal(out_illegal), .out_count(out_count)
  );

  // ---------------- model state ----------------
  int   n_tests = 0;
  int   n_fail  = 0;
  int   p_rdy = 100, p_in = 100, p_sp = 100, p_out = 100;
  bit   fixed_mask_en = 1'b0;
  logic [31:0] fixed_mask = '0;
  ent_t in_q[$];
  ent_t exp_q[$];
  ent_t held;
  bit   held_valid = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit busy();
    return (in_q.size() > 0) || held_valid || (exp_q.size() > 0);
  endfunction

  // kind: 0 LUI 1 AUIPC 2 JAL 3 JALR 4 LOAD 5 ARITHI 6 BRANCH 7 STORE
  //       8 ARITH 9 NOOP 10 illegal
  function automatic ent_t gen(input int kind);
    ent_t e;
    logic [31:0] r;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [6:0]  f7, op;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    logic [6:0]  bad [8];
    bad = '{7'h7F, 7'h00, 7'h5B, 7'h2B, 7'h53, 7'h73, 7'h07, 7'h27};
    e = '{default: '0};
    r = $urandom; rd = 5'($urandom); rs1 = 5'($urandom); rs2 = 5'($urandom);
    f3 = 3'($urandom); f7 = 7'($urandom); i12 = 12'($urandom);
    b13 = {12'($urandom), 1'b0}; j21 = {20'($urandom), 1'b0};
    e.pc = $urandom; e.warp = 5'($urandom); e.split = 4'($urandom);
    case (kind)
      0, 1: begin
        op = (kind == 0) ? 7'h37 : 7'h17;
        e.inst = {r[31:12], rd, op}; e.rd = rd; e.imm = {r[31:12], 12'h000};
      end
      2: begin
        op = 7'h6F;
        e.inst = {j21[20], j21[10:1], j21[11], j21[19:12], rd, op};
        e.rd = rd; e.imm = 32'($signed(j21));
      end
      3, 4, 5: begin
        op = (kind == 3) ? 7'h67 : (kind == 4) ? 7'h03 : 7'h13;
        e.inst = {i12, rs1, f3, rd, op};
        e.rd = rd; e.rs1 = rs1; e.f3 = f3; e.imm = 32'($signed(i12));
      end
      6: begin
        op = 7'h63;
        e.inst = {b13[12], b13[10:5], rs2, rs1, f3, b13[4:1], b13[11], op};
        e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.imm = 32'($signed(b13));
      end
      7: begin
        op = 7'h23;
        e.inst = {i12[11:5], rs2, rs1, f3, i12[4:0], op};
        e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.imm = 32'($signed(i12));
      end
      8: begin
        op = 7'h33;
        e.inst = {f7, rs2, rs1, f3, rd, op};
        e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.f3 = f3; e.f7 = f7;
      end
      9: begin
        op = 7'h0F; e.inst = {r[31:7], op};
      end
      default: begin
        op = bad[r[2:0]]; e.inst = {r[31:7], op}; e.illegal = 1'b1;
      end
    endcase
    e.opcode   = op;
    e.activate = !(kind == 6 && f3 < 3'd2);
    e.stall    = (kind == 1) || (kind == 3) || (kind == 6) || (kind == 10);
    e.sp_pc    = (kind == 2) ? e.pc + e.imm : e.pc + 32'd4;
    return e;
  endfunction

  function automatic ent_t mk(input logic [31:0] inst, input logic [31:0] pc,
                              input logic [6:0] op, input logic [2:0] f3,
                              input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [31:0] imm,
                              input logic ill, input logic act, input logic stall,
                              input logic [31:0] nxt);
    ent_t e;
    e = '{default: '0};
    e.inst = inst; e.pc = pc; e.warp = 5'($urandom); e.split = 4'($urandom);
    e.opcode = op; e.f3 = f3; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.imm = imm;
    e.illegal = ill; e.activate = act; e.stall = stall; e.sp_pc = nxt;
    return e;
  endfunction

  // ---------------- driver + scoreboard, one clock per call ----------------
  task automatic cycle();
    ent_t e;
    bit ofire, spv, spf, inr, inf;
    rdy       = ($urandom_range(0, 99) < p_rdy);
    in_valid  = (in_q.size() > 0) && ($urandom_range(0, 99) < p_in);
    if (in_q.size() > 0) begin
      in_inst = in_q[0].inst; in_pc = in_q[0].pc;
      in_warp = in_q[0].warp; in_split = in_q[0].split;
    end else begin
      in_inst = '0; in_pc = '0; in_warp = '0; in_split = '0;
    end
    sp_ready  = ($urandom_range(0, 99) < p_sp);
    out_ready = ($urandom_range(0, 99) < p_out);
    sp_mask   = fixed_mask_en ? fixed_mask : $urandom;
    #1;
    ofire = rdy && (exp_q.size() > 0) && out_ready;
    spv   = rdy && held_valid && ((exp_q.size() < DEPTH) || ofire);
    spf   = spv && sp_ready;
    inr   = rdy && (!held_valid || spf);
    inf   = inr && in_valid;
    chk("out_valid", 64'(out_valid), 64'(rdy && (exp_q.size() > 0)));
    chk("sp_valid", 64'(sp_valid), 64'(spv));
    chk("in_ready", 64'(in_ready), 64'(inr));
    chk("out_count", 64'(out_count), 64'(exp_q.size()));
    if (exp_q.size() > 0) begin
      chk("out_pc", 64'(out_pc), 64'(exp_q[0].pc));
      chk("out_warp", 64'(out_warp), 64'(exp_q[0].warp));
      chk("out_mask", 64'(out_mask), 64'(exp_q[0].mask));
      chk("out_opcode", 64'(out_opcode), 64'(exp_q[0].opcode));
      chk("out_funct3", 64'(out_funct3), 64'(exp_q[0].f3));
      chk("out_funct7", 64'(out_funct7), 64'(exp_q[0].f7));
      chk("out_rd", 64'(out_rd), 64'(exp_q[0].rd));
      chk("out_rs1", 64'(out_rs1), 64'(exp_q[0].rs1));
      chk("out_rs2", 64'(out_rs2), 64'(exp_q[0].rs2));
      chk("out_imm", 64'(out_imm), 64'(exp_q[0].imm));
      chk("out_illegal", 64'(out_illegal), 64'(exp_q[0].illegal));
    end
    if (held_valid) begin
      chk("sp_warp", 64'(sp_warp), 64'(held.warp));
      chk("sp_split", 64'(sp_split), 64'(held.split));
      chk("sp_activate", 64'(sp_activate), 64'(held.activate));
      chk("sp_stall", 64'(sp_stall), 64'(held.stall));
      chk("sp_pc", 64'(sp_pc), 64'(held.sp_pc));
    end
    if (ofire) void'(exp_q.pop_front());
    if (spf) begin
      e = held; e.mask = sp_mask; exp_q.push_back(e);
    end
    if (inf) begin
      held = in_q.pop_front(); held_valid = 1'b1;
    end else if (spf) begin
      held_valid = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain(input int budget, output int used);
    used = 0;
    while (busy() && used < budget) begin
      cycle();
      used++;
    end
    chk("drain_done", 64'(busy()), 64'(0));
  endtask

  task automatic set_p(input int r, input int i, input int s, input int o);
    p_rdy = r; p_in = i; p_sp = s; p_out = o;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int used;
    rst_n = 1'b0; rdy = 1'b1; in_valid = 1'b1; in_inst = 32'h00500093;
    in_pc = 32'h100; in_warp = '0; in_split = '0;
    sp_ready = 1'b1; out_ready = 1'b1; sp_mask = '1;
    @(negedge clk);
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'(0));
    chk("rst_sp_valid", 64'(sp_valid), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_count", 64'(out_count), 64'(0));
    chk("rst_sp_pc", 64'(sp_pc), 64'(0));
    chk("rst_sp_warp", 64'(sp_warp), 64'(0));
    chk("rst_sp_stall", 64'(sp_stall), 64'(0));
    chk("rst_sp_activate", 64'(sp_activate), 64'(0));
    chk("rst_out_pc", 64'(out_pc), 64'(0));
    chk("rst_out_imm", 64'(out_imm), 64'(0));
    chk("rst_out_opcode", 64'(out_opcode), 64'(0));
    chk("rst_out_illegal", 64'(out_illegal), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Directed decodes: ADDI, JAL -8, BEQ, BLT, opcode 0x7F.
    set_p(100, 100, 100, 100);
    fixed_mask_en = 1'b1; fixed_mask = 32'hFFFF_FFFF;
    in_q.push_back(mk(32'h00500093, 32'h100, 7'h13, 3'd0, 5'd1, 5'd0, 5'd0, 32'd5,
                      1'b0, 1'b1, 1'b0, 32'h104));
    drain(50, used);
    fixed_mask_en = 1'b0;
    in_q.push_back(mk(32'hFF9FF0EF, 32'h200, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_FFF8,
                      1'b0, 1'b1, 1'b0, 32'h1F8));
    in_q.push_back(mk(32'h00208463, 32'h300, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8,
                      1'b0, 1'b0, 1'b1, 32'h304));
    in_q.push_back(mk(32'h0020C463, 32'h400, 7'h63, 3'd4, 5'd0, 5'd1, 5'd2, 32'd8,
                      1'b0, 1'b1, 1'b1, 32'h404));
    in_q.push_back(mk(32'hFFFFFFFF, 32'h500, 7'h7F, 3'd0, 5'd0, 5'd0, 5'd0, 32'd0,
                      1'b1, 1'b1, 1'b1, 32'h504));
    drain(50, used);

    // Fill with out_ready low: DEPTH entries queued, one held in SPLIT.
    set_p(100, 100, 100, 0);
    for (int i = 0; i < DEPTH + 1; i++) in_q.push_back(gen($urandom_range(0, 10)));
    for (int i = 0; i < 12; i++) cycle();
    rdy = 1'b1; in_valid = 1'b0; sp_ready = 1'b1; out_ready = 1'b0;
    #1;
    chk("full_count", 64'(out_count), 64'(DEPTH));
    chk("full_sp_valid", 64'(sp_valid), 64'(0));
    chk("full_in_ready", 64'(in_ready), 64'(0));
    set_p(100, 100, 100, 100);
    cycle();
    chk("full_pushpop_count", 64'(out_count), 64'(DEPTH));
    drain(50, used);

    // Back-to-back throughput: N inputs leave in N+2 cycles.
    for (int i = 0; i < 16; i++) in_q.push_back(gen($urandom_range(0, 10)));
    drain(100, used);
    chk("throughput_cycles", 64'(used), 64'(18));

    // Reset in the middle of traffic discards everything.
    set_p(100, 100, 100, 0);
    for (int i = 0; i < 4; i++) in_q.push_back(gen($urandom_range(0, 10)));
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b0;
    #1;
    held_valid = 1'b0; exp_q.delete(); in_q.delete();
    chk("midrst_sp_valid", 64'(sp_valid), 64'(0));
    chk("midrst_out_valid", 64'(out_valid), 64'(0));
    chk("midrst_out_count", 64'(out_count), 64'(0));
    chk("midrst_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    set_p(100, 100, 100, 100);
    in_q.push_back(gen(5));
    drain(50, used);

    // Stream with rdy toggling.
    set_p(60, 100, 100, 100);
    for (int i = 0; i < 30; i++) in_q.push_back(gen($urandom_range(0, 10)));
    drain(2000, used);

    // Fully random traffic.
    set_p(80, 70, 60, 60);
    for (int i = 0; i < 150; i++) in_q.push_back(gen($urandom_range(0, 10)));
    drain(4000, used);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
